// File: rtl/register_unpipe.sv
// Parallel-in/serial-out: accepts a packed vector of numPipeStage words
// and replays it one word per accepted beat on a valid/ready stream.
//
// Parameters:
//   width         bits per word
//   numPipeStage  words per vector (2..256)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        packed input vector, word k at [width*k +: width]
//   in_valid   din valid
//   in_ready   vector accepted when in_valid && in_ready
//   dout       current output word
//   out_valid  dout valid
//   out_ready  downstream accepts dout
//   out_last   dout is the final beat of its vector
//   out_idx    slice index of the word on dout
//
// Build option: REGISTER_UNPIPE_OLDEST_FIRST_EN emits the highest slice
// first (oldest-first replay of a register-pipe tap vector).
module register_unpipe #(
  parameter int width        = 32,
  parameter int numPipeStage = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [numPipeStage*width-1:0]     din,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [width-1:0]                  dout,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [$clog2(numPipeStage)-1:0]   out_idx
);

  localparam int CW = $clog2(numPipeStage);
  localparam logic [CW-1:0] LAST = CW'(numPipeStage - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [numPipeStage*width-1:0] shadow_q, shadow_d;

  logic          last_beat;
  logic          in_acc;
  logic          out_acc;
  logic [CW-1:0] sel;
  logic [width-1:0] words [numPipeStage];

  for (genvar k = 0; k < numPipeStage; k++) begin : g_words
    assign words[k] = shadow_q[width*k +: width];
  end

  assign last_beat = (cnt_q == LAST);
  assign out_valid = (state_q == SEND);
  assign out_last  = last_beat && out_valid;
  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

`ifdef REGISTER_UNPIPE_OLDEST_FIRST_EN
  assign sel = LAST - cnt_q;
`else
  assign sel = cnt_q;
`endif

  assign dout    = words[sel];
  assign out_idx = sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (out_acc) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A load in the same cycle as the last beat keeps SEND: no bubble.
    if (in_acc) begin
      shadow_d = din;
      cnt_d    = '0;
      state_d  = SEND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_register_unpipe.sv
// Testbench for register_unpipe: directed scenarios plus random traffic
// checked against a beat-queue reference model.
module tb_register_unpipe;

  localparam int W  = 8;
  localparam int N  = 6;
  localparam int CW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N*W-1:0] din;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   dout;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [CW-1:0]  out_idx;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] idx;
  } beat_t;

  beat_t q[$];
  int    n_checks;
  int    n_errors;

  register_unpipe #(
    .width       (W),
    .numPipeStage(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expand an accepted vector into the beats it must produce.
  task automatic push_vec(input logic [N*W-1:0] d);
    beat_t b;
    logic [N*W-1:0] v;
    v = d;
    for (int j = 0; j < N; j++) begin
`ifdef REGISTER_UNPIPE_OLDEST_FIRST_EN
      b.idx = CW'(N - 1 - j);
`else
      b.idx = CW'(j);
`endif
      b.data = v[W*b.idx +: W];
      q.push_back(b);
    end
  endtask

  task automatic step(input logic iv, input logic [N*W-1:0] d,
                      input logic ordy);
    logic ev, eir;
    @(negedge clk);
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    #1;
    ev  = (q.size() != 0);
    eir = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(eir));
    if (ev) begin
      chk("dout", 64'(dout), 64'(q[0].data));
      chk("out_idx", 64'(out_idx), 64'(q[0].idx));
      chk("out_last", 64'(out_last), 64'(q.size() == 1));
    end else begin
      chk("out_last_idle", 64'(out_last), 64'd0);
    end
    @(posedge clk);
    if (ev && ordy) void'(q.pop_front());
    if (iv && eir) push_vec(d);
  endtask

  function automatic logic [N*W-1:0] rnd_vec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N*W-1:0];
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Single vector, full throughput.
    step(1'b1, 48'h060504030201, 1'b1);
    for (int i = 0; i < N + 2; i++) step(1'b0, '0, 1'b1);

    // Back-to-back vectors with in_valid held high.
    step(1'b1, 48'hA5A4A3A2A1A0, 1'b1);
    for (int i = 0; i < N - 1; i++) step(1'b1, 48'hB5B4B3B2B1B0, 1'b1);
    step(1'b1, 48'hB5B4B3B2B1B0, 1'b1);
    for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1);

    // Backpressure while the second beat is presented.
    step(1'b1, 48'h060504030201, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 48'hDEADBEEFCAFE, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1);

    // Mid-vector asynchronous reset after three beats.
    step(1'b1, 48'h060504030201, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    chk("mid_rst_out_idx", 64'(out_idx), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 48'h161514131211, 1'b1);
    for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1), rnd_vec(),
           ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < N + 2; i++) step(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
